// File: rtl/lsu.sv
// Load/store unit sitting behind the ALU. It turns an RV32I load or store
// into one req/gnt/rvalid transaction on the data-memory port and holds the
// single-cycle core in stall until the access retires. Misaligned or
// illegal-width accesses never reach memory; they raise a one-cycle fault.
module lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic [XLEN-1:0] rdata,
  output logic            fault,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t          r_state;
  state_t          w_next;

  logic            w_op;
  logic            w_legal;
  logic            w_aligned;
  logic            w_ok;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_lanes;

  logic            r_req;
  logic            r_we;
  logic            r_fault;
  logic [3:0]      r_be;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_rdata;
  logic [2:0]      r_f3;
  logic [1:0]      r_k;

  // Pick the addressed byte/half out of the returned word and extend it.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] word,
                                               input logic [2:0]      f3,
                                               input logic [1:0]      k);
    logic [XLEN-1:0] sh;
    sh = word >> {k, 3'b000};
    case (f3)
      3'b000:  load_ext = {{(XLEN-8){sh[7]}}, sh[7:0]};
      3'b001:  load_ext = {{(XLEN-16){sh[15]}}, sh[15:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, sh[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, sh[15:0]};
      default: load_ext = word;
    endcase
  endfunction

  // A store wins when both strobes are high, so mem_write alone selects the store rules.
  assign w_op = mem_read | mem_write;

  // Classify the incoming op: legal width, natural alignment, store lanes.
  always_comb begin
    w_legal   = 1'b0;
    w_aligned = 1'b1;
    w_be      = 4'b1111;
    w_lanes   = wdata;
    case (funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = ~mem_write;
      default:                w_legal = 1'b0;
    endcase
    case (funct3[1:0])
      2'b01:   w_aligned = ~addr[0];
      2'b10:   w_aligned = (addr[1:0] == 2'b00);
      default: w_aligned = 1'b1;
    endcase
    if (mem_write) begin
      case (funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << addr[1:0];
          w_lanes = {4{wdata[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << addr[1:0];
          w_lanes = {2{wdata[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_lanes = wdata;
        end
      endcase
    end
  end

  assign w_ok  = w_op & w_legal & w_aligned;
  assign stall = w_ok & (r_state != DONE);

  // Next-state logic for the access sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_ok) w_next = REQ;
      REQ:     if (dmem_gnt) w_next = r_we ? DONE : WAIT;
      WAIT:    if (dmem_rvalid) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Memory request, fault pulse and load result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_be    <= 4'b0000;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_fault <= 1'b0;
      r_f3    <= 3'b000;
      r_k     <= 2'b00;
    end else begin
      r_fault <= (r_state == IDLE) & w_op & ~w_ok;
      case (r_state)
        IDLE: begin
          if (w_ok) begin
            r_req   <= 1'b1;
            r_we    <= mem_write;
            r_be    <= w_be;
            r_addr  <= {addr[XLEN-1:2], 2'b00};
            r_wdata <= w_lanes;
            r_f3    <= funct3;
            r_k     <= addr[1:0];
          end
        end
        REQ: begin
          if (dmem_gnt) r_req <= 1'b0;
        end
        WAIT: begin
          if (dmem_rvalid) r_rdata <= load_ext(dmem_rdata, r_f3, r_k);
        end
        default: begin
        end
      endcase
    end
  end

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_be    = r_be;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign rdata      = r_rdata;
  assign fault      = r_fault;

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit that sits directly downstream of the ALU.
- Takes the ALU result as the effective address and rs2 as store data.
- Performs the RV32I LB/LH/LW/LBU/LHU/SB/SH/SW access over a req/gnt/rvalid data-memory handshake.
- Stalls the single-cycle core until the access completes, then returns sign- or zero-extended load data to the writeback mux.

Parameters:
- XLEN, 32, data and address width; only 32 is supported.

Ports:
- clk  in  1  core clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_read  in  1  load instruction in the current cycle
- mem_write  in  1  store instruction in the current cycle
- funct3  in  3  RV32I width/sign field
- addr  in  XLEN  effective address (ALU output)
- wdata  in  XLEN  store data (rs2)
- stall  out  1  hold the PC and pipeline inputs (combinational)
- rdata  out  XLEN  extended load result (registered)
- fault  out  1  one-cycle pulse: misaligned access or illegal funct3
- dmem_req  out  1  memory request (registered)
- dmem_we  out  1  1 = write
- dmem_addr  out  XLEN  word-aligned address, {addr[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid this cycle
- dmem_rdata  in  XLEN  read word

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, rdata and fault all clear to 0.
  - An access in flight is abandoned. A dmem_rvalid arriving after reset is ignored.
- States: IDLE, REQ, WAIT, DONE.
- op = mem_read | mem_write. If both are high, treat as a store and ignore mem_read.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
- Alignment: half-word requires addr[0]=0; word requires addr[1:0]=00.
- IDLE:
  - op with illegal funct3 or misalignment: fault=1 next cycle for exactly one cycle, no request issued, stall=0, state stays IDLE.
  - Legal op: register dmem_addr/we/be/wdata, set dmem_req=1, go to REQ.
- REQ:
  - dmem_req and all dmem_* outputs held stable until dmem_gnt=1.
  - On gnt, dmem_req drops next cycle. Store goes to DONE; load goes to WAIT.
- WAIT:
  - dmem_rvalid is never expected in the gnt cycle.
  - On rvalid, capture the extended load result into rdata and go to DONE.
- DONE: one cycle with stall=0; the core retires on this edge. Then go to IDLE.
- stall = op & legal & aligned & (state != DONE).
  - While stall=1 the core holds mem_read, mem_write, funct3, addr and wdata constant.
- Store lanes, with k=addr[1:0]:
  - SB: be=4'b0001<<k, wdata lanes = {4{wdata[7:0]}}.
  - SH: be=4'b0011<<k, lanes = {2{wdata[15:0]}}.
  - SW: be=4'b1111, lanes = wdata.
- Loads: dmem_be=4'b1111 and dmem_we=0. Byte or half-word selected by addr[1:0]:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- rdata holds its value until the next load completes; stores do not change it.
- Minimum latency with gnt in the first REQ cycle:
  - Store: stall high for 2 cycles, retire in cycle 3.
  - Load with rvalid one cycle after gnt: stall high for 3 cycles, retire in cycle 4.
- Back-to-back ops: a new op seen in IDLE right after DONE starts a fresh access with no bubble beyond the IDLE cycle.
- gnt held low indefinitely: the unit stays in REQ. There is no timeout.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt immediate -> dmem_addr=0x100, be=1111, wdata=0xDEADBEEF, we=1; stall high exactly 2 cycles; dmem_req high exactly 1 cycle.
- SB addr=0x103, wdata=0x000000A5 -> be=1000, dmem_wdata=0xA5A5A5A5. SH addr=0x102, wdata=0x1234 -> be=1100, dmem_wdata=0x12341234.
- Load 0x80F0_7F01 from addr 0x200, rvalid 1 cycle after gnt:
  - LB addr=0x203 -> rdata=0xFFFFFF80.
  - LBU addr=0x203 -> 0x00000080.
  - LH addr=0x202 -> 0xFFFF80F0.
  - LHU addr=0x200 -> 0x00007F01.
  - LW -> 0x80F07F01.
  - Each with stall high 3 cycles.
- LW addr=0x102, SH addr=0x101, and funct3=011 load -> fault pulses 1 cycle; dmem_req never rises; stall stays 0; rdata unchanged.
- gnt delayed 5 cycles and rvalid delayed 4 more -> dmem_* outputs stable throughout REQ; stall high for 11 cycles; rdata is correct at DONE.
- rst_n asserted while in WAIT, then a stray rvalid after release -> all outputs 0 immediately; state IDLE; stray rvalid does not change rdata.
